// File: rtl/uvmt_cvmcu_obi_mem_slv.sv
// OBI slave memory model: byte-enable writes, fixed response latency,
// bounded in-order response queue with backpressure and range errors.
module uvmt_cvmcu_obi_mem_slv #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH           = 1024,
    parameter int RSP_LATENCY     = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   req_i,
    output logic                                   gnt_o,
    input  logic [ADDR_WIDTH-1:0]                  addr_i,
    input  logic                                   we_i,
    input  logic [DATA_WIDTH/8-1:0]                be_i,
    input  logic [DATA_WIDTH-1:0]                  wdata_i,
    output logic                                   rvalid_o,
    input  logic                                   rready_i,
    output logic [DATA_WIDTH-1:0]                  rdata_o,
    output logic                                   err_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

    localparam int BE_W    = DATA_WIDTH / 8;
    localparam int IDX_LSB = $clog2(BE_W);
    localparam int IDX_W   = ADDR_WIDTH - IDX_LSB;
    localparam int MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int TMR_W   = 4;

    typedef struct packed {
        logic                  err;
        logic [DATA_WIDTH-1:0] data;
        logic [TMR_W-1:0]      tmr;
    } rsp_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    rsp_t                  q   [MAX_OUTSTANDING];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] idx;
    logic [MEM_AW-1:0] midx;
    logic             in_range;
    logic             accept;
    logic             pop;

    assign idx      = addr_i[ADDR_WIDTH-1:IDX_LSB];
    assign midx     = idx[MEM_AW-1:0];
    assign in_range = {1'b0, idx} < (IDX_W + 1)'(DEPTH);

    generate
        if (IDX_LSB > 0) begin : g_lsb
            logic unused_lsb;
            assign unused_lsb = ^addr_i[IDX_LSB-1:0];
        end
    endgenerate

    // Grant looks only at the registered count, never at a same-cycle pop.
    assign gnt_o  = req_i & ~reset & (count < CNT_W'(MAX_OUTSTANDING));
    assign accept = req_i & gnt_o;

    assign rvalid_o      = (count != '0) & (q[rd_ptr].tmr == '0);
    assign rdata_o       = rvalid_o ? q[rd_ptr].data : '0;
    assign err_o         = rvalid_o & q[rd_ptr].err;
    assign pop           = rvalid_o & rready_i;
    assign outstanding_o = count;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Array has no reset so contents survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (accept && we_i && in_range) begin
            for (int k = 0; k < BE_W; k++) begin
                if (be_i[k]) mem[midx][k*8 +: 8] <= wdata_i[k*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (q[i].tmr != '0) q[i].tmr <= q[i].tmr - 1'b1;
        end
        if (accept) begin
            q[wr_ptr].err  <= ~in_range;
            q[wr_ptr].data <= (we_i || !in_range) ? '0 : mem[midx];
            q[wr_ptr].tmr  <= TMR_W'(RSP_LATENCY - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (accept) wr_ptr <= nxt(wr_ptr);
            if (pop)    rd_ptr <= nxt(rd_ptr);
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uvmt_cvmcu_obi_mem_slv.sv
// Directed bench for the OBI slave memory with a response scoreboard
// fed at each accept and drained at each response handshake.
module tb_uvmt_cvmcu_obi_mem_slv;

    logic        clk;
    logic        reset;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic        rready_i;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [2:0]  outstanding_o;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mm [int];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] hold_d;
    logic        hold_e;

    uvmt_cvmcu_obi_mem_slv dut (
        .clk           (clk),
        .reset         (reset),
        .req_i         (req_i),
        .gnt_o         (gnt_o),
        .addr_i        (addr_i),
        .we_i          (we_i),
        .be_i          (be_i),
        .wdata_i       (wdata_i),
        .rvalid_o      (rvalid_o),
        .rready_i      (rready_i),
        .rdata_o       (rdata_o),
        .err_o         (err_o),
        .outstanding_o (outstanding_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop on handshake first, then push on accept.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (rvalid_o && rready_i) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_rdata", rdata_o, e.data);
                    check("sb_err", 32'(err_o), 32'(e.err));
                end
            end
            if (req_i && gnt_o) begin
                exp_t e;
                int   idx;
                logic [31:0] w;
                idx = int'(addr_i >> 2);
                if (idx >= 1024) begin
                    e = '{32'h0, 1'b1};
                end else if (we_i) begin
                    w = mm.exists(idx) ? mm[idx] : 32'h0;
                    for (int k = 0; k < 4; k++)
                        if (be_i[k]) w[k*8 +: 8] = wdata_i[k*8 +: 8];
                    mm[idx] = w;
                    e = '{32'h0, 1'b0};
                end else begin
                    e = '{(mm.exists(idx) ? mm[idx] : 32'hx), 1'b0};
                end
                sb.push_back(e);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        int n = 0;
        req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wd;
        @(negedge clk);
        while (!gnt_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("gnt_wait", 32'(gnt_o), 32'd1);
        @(posedge clk);
        #1;
        req_i = 1'b0;
        we_i  = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [31:0] d,
                            input logic e);
        int n = 0;
        @(negedge clk);
        while (!rvalid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rvalid"}, 32'(rvalid_o), 32'd1);
        check({tag, "_rdata"}, rdata_o, d);
        check({tag, "_err"}, 32'(err_o), 32'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10;
        be_i = 4'hF; wdata_i = '0; rready_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(gnt_o), 32'd0);
        check("rst_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_outst", 32'(outstanding_o), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0; req_i = 1'b0;

        issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        issue(1'b1, 32'h20, 4'hF, 32'h12345678);
        issue(1'b1, 32'h04, 4'hF, 32'h11111111);
        idle(4);

        // Latency: accept edge N, rvalid visible before edge N+2.
        issue(1'b0, 32'h10, 4'hF, 32'h0);
        @(negedge clk);
        check("lat_early", 32'(rvalid_o), 32'd0);
        @(negedge clk);
        check("lat_rvalid", 32'(rvalid_o), 32'd1);
        check("lat_rdata", rdata_o, 32'hDEADBEEF);
        check("lat_err", 32'(err_o), 32'd0);
        idle(2);

        issue(1'b1, 32'h10, 4'b0010, 32'h0000AB00);
        idle(3);
        issue(1'b0, 32'h10, 4'hF, 32'h0);
        wait_rsp("pwr", 32'hDEADABEF, 1'b0);
        idle(2);

        issue(1'b0, 32'h1000, 4'hF, 32'h0);
        wait_rsp("oor_rd", 32'h0, 1'b1);
        idle(2);
        issue(1'b1, 32'h1004, 4'hF, 32'hFFFFFFFF);
        wait_rsp("oor_wr", 32'h0, 1'b1);
        idle(2);
        issue(1'b0, 32'h04, 4'hF, 32'h0);
        wait_rsp("alias", 32'h11111111, 1'b0);
        idle(2);

        // Fill the queue under backpressure, then drain.
        rready_i = 1'b0;
        issue(1'b0, 32'h10, 4'hF, 32'h0);
        issue(1'b0, 32'h20, 4'hF, 32'h0);
        issue(1'b0, 32'h04, 4'hF, 32'h0);
        issue(1'b0, 32'h1000, 4'hF, 32'h0);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h20;
        @(negedge clk);
        check("full_gnt", 32'(gnt_o), 32'd0);
        check("full_outst", 32'(outstanding_o), 32'd4);
        check("hold_rvalid0", 32'(rvalid_o), 32'd1);
        check("hold_head", rdata_o, 32'hDEADABEF);
        hold_d = rdata_o;
        hold_e = err_o;
        repeat (2) begin
            @(negedge clk);
            check("hold_rvalid", 32'(rvalid_o), 32'd1);
            check("hold_rdata", rdata_o, hold_d);
            check("hold_err", 32'(err_o), 32'(hold_e));
        end
        @(posedge clk);
        #1;
        rready_i = 1'b1;
        @(negedge clk);
        check("pop_gnt0", 32'(gnt_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("regrant", 32'(gnt_o), 32'd1);
        check("b2b_1", 32'(rvalid_o), 32'd1);
        check("b2b_outst", 32'(outstanding_o), 32'd3);
        @(posedge clk);
        #1;
        req_i = 1'b0;
        @(negedge clk);
        check("b2b_2", 32'(rvalid_o), 32'd1);
        check("push_pop_outst", 32'(outstanding_o), 32'd3);
        @(negedge clk);
        check("b2b_3", 32'(rvalid_o), 32'd1);
        check("b2b_3_err", 32'(err_o), 32'd1);
        idle(4);
        @(negedge clk);
        check("drain_outst", 32'(outstanding_o), 32'd0);
        check("drain_rvalid", 32'(rvalid_o), 32'd0);

        // Reset with three responses in flight.
        @(posedge clk);
        #1;
        rready_i = 1'b0;
        issue(1'b0, 32'h10, 4'hF, 32'h0);
        issue(1'b0, 32'h20, 4'hF, 32'h0);
        issue(1'b0, 32'h04, 4'hF, 32'h0);
        @(negedge clk);
        check("pre_rst_outst", 32'(outstanding_o), 32'd3);
        @(posedge clk);
        #1;
        reset = 1'b1; req_i = 1'b1; addr_i = 32'h10;
        @(negedge clk);
        check("rst_gnt_mask", 32'(gnt_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("flush_rvalid", 32'(rvalid_o), 32'd0);
        check("flush_outst", 32'(outstanding_o), 32'd0);
        check("flush_gnt", 32'(gnt_o), 32'd0);
        check("flush_rdata", rdata_o, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0; req_i = 1'b0; rready_i = 1'b1;
        issue(1'b0, 32'h20, 4'hF, 32'h0);
        wait_rsp("post_rst", 32'h12345678, 1'b0);
        idle(3);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
